// File: rtl/dmem_responder_if.sv
// Load/store request/response bus between the MEM stage and the data-memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_func3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_func3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV32 load/store, byte-lane stores,
// loads returned after READ_LAT cycles, error response for bad accesses.
module dmem_responder #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter int unsigned READ_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus,
  output logic            busy
);

  localparam int unsigned IdxW      = $clog2(MEM_SIZE);
  localparam logic [33:0] ByteLimit = 34'(MEM_SIZE) * 34'd4;

  typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [2:0]  func3_q, func3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q;

  logic [31:0] mem [MEM_SIZE];

  logic            accept;
  logic [IdxW-1:0] idx;
  logic [2:0]      f3;
  logic [1:0]      lane;
  logic            is_half, is_word, bad_func3, req_err;
  logic            we;
  logic [3:0]      be;
  logic [31:0]     wdata_rep;
  logic [31:0]     mem_rd;

  // Extend the addressed byte/halfword of a word according to the load func3.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] ln,
                                           input logic [2:0] fc);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (fc)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Request decode: acceptance, error detection and store byte enables.
  always_comb begin
    accept    = bus.req_valid && (state_q == StIdle);
    idx       = bus.req_addr[IdxW+1:2];
    f3        = bus.req_func3;
    lane      = bus.req_addr[1:0];
    is_half   = (f3[1:0] == 2'b01);
    is_word   = (f3[1:0] == 2'b10);
    bad_func3 = bus.req_write ? (f3 > 3'b010)
                              : ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
    req_err   = (34'(bus.req_addr) >= ByteLimit) || (is_half && lane[0]) ||
                (is_word && (lane != 2'b00)) || bad_func3;
    we        = accept && bus.req_write && !req_err;
    mem_rd    = mem[idx];
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    case (f3[1:0])
      2'b00:   wdata_rep = {4{bus.req_wdata[7:0]}};
      2'b01:   wdata_rep = {2{bus.req_wdata[15:0]}};
      default: wdata_rep = bus.req_wdata;
    endcase
  end

  // Memory array (never reset); the load word is snapshotted at acceptance.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
    if (accept) word_q <= mem_rd;
  end

  // State and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      func3_q <= 3'd0;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      func3_q <= func3_d;
      lane_q  <= lane_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    func3_d = func3_q;
    lane_d  = lane_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          func3_d = f3;
          lane_d  = lane;
          rdata_d = 32'd0;
          err_d   = req_err;
          if (req_err || bus.req_write) begin
            state_d = StResp;
          end else if (READ_LAT <= 1) begin
            state_d = StResp;
            rdata_d = fmt_load(mem_rd, lane, f3);
          end else begin
            state_d = StRdWait;
            cnt_d   = 2'(READ_LAT - 1);
          end
        end
      end
      StRdWait: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          state_d = StResp;
          rdata_d = fmt_load(word_q, lane_q, func3_q);
          err_d   = 1'b0;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the MEM stage: the target end of the load/store interface that the memory stage drives. It accepts one request at a time over a valid/ready handshake and performs RV32 sub-word stores (SB/SH/SW) and loads (LB/LH/LW/LBU/LHU) selected by func3. Reads return after a programmable latency; writes return an acknowledge. Misaligned, out-of-range and illegal-func3 accesses return an error response.

## Interface
- MEM_SIZE, default 1024: memory depth in 32-bit words (power of two, ≥ 4).
- READ_LAT, default 2: cycles from read acceptance to response (legal range 1..4).

- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_func3  input  3  RV32 width/sign code.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low bits are used for SB/SH.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator takes the response.
- rsp_rdata  output  32  load result, extended per func3; 0 for stores and errors.
- rsp_err  output  1  response is an error; qualified by rsp_valid.
- busy  output  1  state is not IDLE.

## Operation
- FSM states: IDLE, RD_WAIT, RESP.
- req_ready = 1 only in IDLE. A request is accepted on a clock edge where req_valid && req_ready.
- Request latch: the responder captures addr, func3 and write at acceptance. Later changes on req_* have no effect.
- Error detection at acceptance, with any one condition sufficient:
  - addr ≥ 4*MEM_SIZE.
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] ≠ 0.
  - Load func3 ∈ {011, 110, 111}.
  - Store func3 ≥ 011.
- On error: no memory write, go to RESP with rsp_err = 1 and rsp_rdata = 0.
- Store with no error, committed at the acceptance edge:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes. Other lanes keep their value.
  - Then go to RESP with rsp_err = 0 and rsp_rdata = 0.
- Load with no error: go to RD_WAIT and load a down-counter with READ_LAT-1.
  - The memory word is read from the latched address at acceptance, so a preceding store is visible.
  - When the counter hits 0, format the result and go to RESP:
    - LB/LH sign-extend from bit 7/15.
    - LBU/LHU zero-extend.
    - LW passes the word unchanged.
  - If READ_LAT = 1, go directly to RESP.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready = 1, then the FSM returns to IDLE. A new request is not accepted in the same cycle as the response handshake.
- Word index = addr[log2(MEM_SIZE)+1:2].
- Memory array is not cleared by reset; initial contents are undefined.
- Reset asserted (reset = 0): FSM goes to IDLE at once. Any in-flight load is aborted and produces no response. A store already committed stays written.

## Timing
- Reset values:
  - req_ready = 1.
  - rsp_valid = 0.
  - rsp_rdata = 0.
  - rsp_err = 0.
  - busy = 0.
  - Latency counter = 0.
- Store or error accepted at edge T: rsp_valid rises after T; earliest handshake at edge T+1; req_ready is high again after that edge.
- Load accepted at edge T: rsp_valid rises after edge T+READ_LAT-1, giving READ_LAT cycles from acceptance.
- Maximum throughput is one request per 2 cycles (store) or READ_LAT+1 cycles (load), with rsp_ready held high.
- rsp_ready low in RESP: the response holds indefinitely.
- rsp_ready asserted while not in RESP: ignored.
- Release of reset (reset 0→1): the first accept can occur at the first rising clk edge after release.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 with READ_LAT = 2 → store ack has rsp_err = 0, rdata = 0; load rsp_valid occurs 2 cycles after accept with rdata 0xDEADBEEF.
- SB 0x80 to 0x11, then LB 0x11 and LBU 0x11 → LB returns 0xFFFFFF80, LBU returns 0x00000080; LW 0x10 returns 0xDEAD80EF.
- SH 0x1234 to 0x12 → LW 0x10 returns 0x123480EF; LH 0x12 returns 0x00001234.
- Error cases, each giving rsp_err = 1, rdata = 0 and leaving memory unchanged (confirmed by a later LW 0x10 = 0x123480EF):
  - LW 0x13 (misaligned).
  - SH 0x11 (misaligned).
  - LW 0x1000 with MEM_SIZE = 1024 (out of range).
  - Load func3 = 111 (illegal).
- Backpressure: hold rsp_ready low for 5 cycles in RESP → rsp_valid/rdata stay stable, req_ready stays 0, and a second req_valid is not accepted.
- Reset mid-read: assert reset during RD_WAIT → outputs go to reset values immediately; no rsp_valid after release; the next LW completes normally.
